// File: rtl/hv_alu_pkg.sv
// hv_alu_pkg: shared op/state encodings and default sizing for the HV ALU sequencer.
package hv_alu_pkg;
    localparam int HVDimension = 512;
    localparam int NumOps      = 4;
    localparam int MaxShiftAmt = 128;
    localparam int MaxIter     = 15;

    typedef enum logic [1:0] {
        OpXor   = 2'd0,
        OpAnd   = 2'd1,
        OpOr    = 2'd2,
        OpShift = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/hv_alu_pe.sv
// hv_alu_pe: combinational HV ALU step (xor/and/or/rotate-right) on a_i with b_i.
// Ports: a_i, b_i operands; op_i selects the op; shift_amt_i rotate amount; res_o result.
module hv_alu_pe #(
    parameter int HVDimension = 512,
    parameter int NumOpsWidth = 2,
    parameter int ShiftWidth  = 7
) (
    input  logic [HVDimension-1:0] a_i,
    input  logic [HVDimension-1:0] b_i,
    input  logic [NumOpsWidth-1:0] op_i,
    input  logic [ShiftWidth-1:0]  shift_amt_i,
    output logic [HVDimension-1:0] res_o
);
    import hv_alu_pkg::*;

    logic [HVDimension-1:0] rot;

    // A zero shift makes the left term shift out completely, leaving a_i unchanged.
    always_comb begin
        rot   = (a_i >> shift_amt_i) | (a_i << (HVDimension - int'(shift_amt_i)));
        res_o = op_i == NumOpsWidth'(OpXor) ? a_i ^ b_i :
                op_i == NumOpsWidth'(OpAnd) ? a_i & b_i :
                op_i == NumOpsWidth'(OpOr)  ? a_i | b_i : rot;
    end
endmodule

// File: rtl/hv_alu_seq.sv
// hv_alu_seq: command sequencer applying acc <= op(acc, b) N times, result on valid/ready.
// Ports: cmd_* command handshake and payload; abort_i drops work; res_* result handshake;
// busy_o high while a command is in flight (RUN or DONE).
module hv_alu_seq #(
    parameter int HVDimension = hv_alu_pkg::HVDimension,
    parameter int NumOps      = hv_alu_pkg::NumOps,
    parameter int NumOpsWidth = $clog2(NumOps),
    parameter int MaxShiftAmt = hv_alu_pkg::MaxShiftAmt,
    parameter int ShiftWidth  = $clog2(MaxShiftAmt),
    parameter int MaxIter     = hv_alu_pkg::MaxIter,
    parameter int IterWidth   = $clog2(MaxIter + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [NumOpsWidth-1:0] cmd_op_i,
    input  logic [ShiftWidth-1:0]  cmd_shift_amt_i,
    input  logic [IterWidth-1:0]   cmd_iter_i,
    input  logic [HVDimension-1:0] cmd_a_i,
    input  logic [HVDimension-1:0] cmd_b_i,
    input  logic                   abort_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [HVDimension-1:0] res_o,
    output logic                   busy_o
);
    import hv_alu_pkg::*;

    state_e                 state_q, state_d;
    logic [HVDimension-1:0] acc, b_reg, pe_out;
    logic [NumOpsWidth-1:0] op_reg;
    logic [ShiftWidth-1:0]  shift_reg;
    logic [IterWidth-1:0]   cnt, iter_sat;
    logic                   accept;

    // Saturation only matters when the iteration field can encode more than MaxIter.
    if (MaxIter < 2 ** IterWidth - 1) begin : g_sat
        assign iter_sat = cmd_iter_i > IterWidth'(MaxIter) ? IterWidth'(MaxIter) : cmd_iter_i;
    end else begin : g_nosat
        assign iter_sat = cmd_iter_i;
    end

    assign cmd_ready_o = state_q == IDLE && !abort_i;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign res_valid_o = state_q == DONE;
    assign res_o       = acc;
    assign busy_o      = state_q != IDLE;

    hv_alu_pe #(
        .HVDimension(HVDimension),
        .NumOpsWidth(NumOpsWidth),
        .ShiftWidth (ShiftWidth)
    ) u_pe (
        .a_i        (acc),
        .b_i        (b_reg),
        .op_i       (op_reg),
        .shift_amt_i(shift_reg),
        .res_o      (pe_out)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !accept ? IDLE : iter_sat == '0 ? DONE : RUN;
            RUN:     state_d = abort_i ? IDLE : cnt == IterWidth'(1) ? DONE : RUN;
            DONE:    state_d = abort_i || res_ready_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // An abort in RUN skips the pending update; acc keeps its last value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            acc       <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            shift_reg <= '0;
            cnt       <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                acc       <= cmd_a_i;
                b_reg     <= cmd_b_i;
                op_reg    <= cmd_op_i;
                shift_reg <= cmd_shift_amt_i;
                cnt       <= iter_sat;
            end else if (state_q == RUN && !abort_i) begin
                acc <= pe_out;
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hv_alu_seq.sv
// tb_hv_alu_seq: directed and randomized checks of hv_alu_seq against a transaction-level model.
module tb_hv_alu_seq;
    localparam int W = 512;

    logic         clk = 0, rst_n = 1, cmd_valid = 0, abort = 0, res_ready = 1;
    logic [1:0]   cmd_op = '0;
    logic [6:0]   cmd_sh = '0;
    logic [3:0]   cmd_iter = '0;
    logic [W-1:0] cmd_a = '0, cmd_b = '0;
    logic         cmd_ready, res_valid, busy;
    logic [W-1:0] res;
    int           checks = 0, errors = 0;

    always #5 clk = ~clk;

    hv_alu_seq dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_op_i       (cmd_op),
        .cmd_shift_amt_i(cmd_sh),
        .cmd_iter_i     (cmd_iter),
        .cmd_a_i        (cmd_a),
        .cmd_b_i        (cmd_b),
        .abort_i        (abort),
        .res_valid_o    (res_valid),
        .res_ready_i    (res_ready),
        .res_o          (res),
        .busy_o         (busy)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Result of applying the op n times, computed bit by bit from the op definitions.
    function automatic logic [W-1:0] ref_run(input int op, input int sh, input int n,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y;
        x = a;
        for (int k = 0; k < n; k++) begin
            if (op == 0) x = x ^ b;
            else if (op == 1) x = x & b;
            else if (op == 2) x = x | b;
            else begin
                for (int i = 0; i < W; i++) y[i] = x[(i + sh) % W];
                x = y;
            end
        end
        return x;
    endfunction

    // Transaction model: busy from accept until result handshake or abort; result
    // becomes visible after the requested number of cycles.
    logic         m_busy = 0, m_valid = 0;
    int           m_left = 0;
    logic [W-1:0] m_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 0;
            m_valid <= 0;
            m_left  <= 0;
        end else if (!m_busy) begin
            if (cmd_valid && !abort) begin
                m_busy  <= 1;
                m_res   <= ref_run(int'(cmd_op), int'(cmd_sh), int'(cmd_iter), cmd_a, cmd_b);
                m_left  <= int'(cmd_iter);
                m_valid <= cmd_iter == 0;
            end
        end else if (abort || (m_valid && res_ready)) begin
            m_busy  <= 0;
            m_valid <= 0;
        end else if (!m_valid) begin
            m_left  <= m_left - 1;
            m_valid <= m_left == 1;
        end
    end

    always @(negedge clk) begin
        chk("cmd_ready", W'(cmd_ready), W'(!m_busy && !abort));
        chk("busy", W'(busy), W'(m_busy));
        chk("res_valid", W'(res_valid), W'(m_valid));
        if (m_valid) chk("res", res, m_res);
    end

    task automatic rnd_hv(output logic [W-1:0] v);
        for (int w = 0; w < W / 32; w++) v[w*32 +: 32] = $urandom;
    endtask

    task automatic send(input int op, input int sh, input int n,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        int   k;
        logic got;
        cmd_valid = 1;
        cmd_op    = 2'(op);
        cmd_sh    = 7'(sh);
        cmd_iter  = 4'(n);
        cmd_a     = a;
        cmd_b     = b;
        k = 0;
        do begin
            @(negedge clk);
            got = cmd_ready;
            @(posedge clk);
            #2;
            k++;
        end while (!got && k < 20);
        if (!got) chk("accept_timeout", W'(0), W'(1));
        cmd_valid = 0;
    endtask

    task automatic wait_res(output logic [W-1:0] r, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!res_valid && lat < 40);
        if (!res_valid) chk("result_timeout", W'(0), W'(1));
        r = res;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [W-1:0] r, a, b, c, exp;
        int           lat, k, seen;
        logic         got;
        #1 rst_n = 0;
        @(negedge clk);
        chk("rst_cmd_ready", W'(cmd_ready), W'(1));
        chk("rst_res_valid", W'(res_valid), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_res", res, '0);
        #7 rst_n = 1;
        @(posedge clk);
        #2;

        send(0, 0, 1, W'('hF0), W'('hFF));
        wait_res(r, lat);
        chk("xor1_res", r, W'('h0F));
        chk("xor1_lat", W'(lat), W'(2));
        @(negedge clk);
        chk("xor1_pulse", W'(res_valid), W'(0));
        chk("xor1_ready_after", W'(cmd_ready), W'(1));
        @(posedge clk);
        #2;

        send(0, 0, 2, W'('h1234), W'('hABCD));
        wait_res(r, lat);
        chk("xor2_res", r, W'('h1234));
        chk("xor2_lat", W'(lat), W'(3));

        send(0, 0, 0, W'('h55), W'('h0));
        wait_res(r, lat);
        chk("iter0_res", r, W'('h55));
        chk("iter0_lat", W'(lat), W'(1));

        exp = '0;
        exp[508] = 1'b1;
        send(3, 1, 4, W'(1), '0);
        wait_res(r, lat);
        chk("rot1x4_res", r, exp);

        exp = '0;
        exp[389] = 1'b1;
        send(3, 127, 5, W'(1), '0);
        wait_res(r, lat);
        chk("rot127x5_res", r, exp);

        // Backpressure with a command held pending during DONE.
        res_ready = 0;
        rnd_hv(a);
        rnd_hv(b);
        send(1, 0, 3, a, b);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!res_valid && lat < 40);
        r = res;
        chk("bp_res", r, a & b);
        @(posedge clk);
        #2;
        rnd_hv(c);
        cmd_valid = 1;
        cmd_op    = 2'd2;
        cmd_sh    = '0;
        cmd_iter  = 4'd1;
        cmd_a     = b;
        cmd_b     = c;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_stable", res, r);
            chk("bp_busy", W'(busy), W'(1));
            chk("bp_no_ready", W'(cmd_ready), W'(0));
        end
        @(posedge clk);
        #2;
        res_ready = 1;
        k = 0;
        do begin
            @(negedge clk);
            got = cmd_ready;
            @(posedge clk);
            #2;
            k++;
        end while (!got && k < 10);
        chk("bp_accept_gap", W'(k), W'(2));
        cmd_valid = 0;
        wait_res(r, lat);
        chk("bp_next_res", r, b | c);

        // Abort in the third RUN cycle.
        rnd_hv(a);
        rnd_hv(b);
        send(0, 0, 8, a, b);
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        abort = 1;
        @(posedge clk);
        #2;
        abort = 0;
        chk("abort_idle", W'(busy), W'(0));
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            seen += int'(res_valid);
        end
        chk("abort_no_res", W'(seen), W'(0));
        @(posedge clk);
        #2;
        send(0, 0, 3, a, b);
        wait_res(r, lat);
        chk("after_abort_res", r, a ^ b);

        // Asynchronous reset mid-RUN.
        rnd_hv(a);
        rnd_hv(b);
        send(3, 5, 10, a, b);
        @(posedge clk);
        #2;
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("arst_busy", W'(busy), W'(0));
        chk("arst_valid", W'(res_valid), W'(0));
        chk("arst_res", res, '0);
        chk("arst_ready", W'(cmd_ready), W'(1));
        #5 rst_n = 1;
        @(posedge clk);
        #2;
        send(0, 0, 1, a, b);
        wait_res(r, lat);
        chk("after_arst_res", r, a ^ b);

        repeat (1500) begin
            @(posedge clk);
            #2;
            cmd_valid = 1'($urandom);
            cmd_op    = 2'($urandom);
            cmd_sh    = 7'($urandom);
            cmd_iter  = 4'($urandom);
            rnd_hv(cmd_a);
            rnd_hv(cmd_b);
            abort     = $urandom_range(0, 39) == 0;
            res_ready = $urandom_range(0, 3) != 0;
        end
        @(posedge clk);
        #2;
        cmd_valid = 0;
        abort     = 0;
        res_ready = 1;
        repeat (20) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
